irq_ctrl: RTL

Parametrised interrupt controller for the 6502-class CPU core. It synchronises one active-low NMI line and N_IRQ active-low IRQ lines and resolves priority: reset, then NMI, then the lowest-index IRQ. It presents a single registered `pending` flag plus the low byte of the vector address, which the CPU places on page $FF. It replaces the fixed RST/NMI/IRQ logic inside the core with a multi-source, maskable version that holds its selection steady during the vector fetch.

---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_sync.sv | 21 ++
 rtl/irq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and vector constants for the multi-source interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IRQ  = 2'd1,
        SRC_NMI  = 2'd2,
        SRC_RST  = 2'd3
    } src_kind_t;

    localparam logic [7:0] VEC_RST  = 8'hFC;
    localparam logic [7:0] VEC_NMI  = 8'hFA;
    localparam logic [7:0] VEC_IRQ0 = 8'hFE;

    // IRQ0 keeps the legacy $FE slot; the extra channels sit on a table at base.
    function automatic logic [7:0] irq_vec(input int idx, input logic [7:0] base);
        return (idx == 0) ? VEC_IRQ0 : base + 8'(2 * (idx - 1));
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser; bits reset high because request lines idle high.
module irq_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         dclk,
    input  logic         n_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_chain;

    always_ff @(posedge dclk or negedge n_reset) begin
        if (!n_reset) r_chain <= '1;
        else          r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: RST > NMI > lowest-index IRQ, selection frozen while lock is high.
// Build option IRQ_CTRL_MASK_EN adds a writable per-channel IRQ mask register.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         N_IRQ       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VEC_BASE    = 8'hE0,
    parameter int         ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             dclk,
    input  logic             n_reset,
    input  logic             n_nmi,
    input  logic [N_IRQ-1:0] n_irq,
    input  logic             soft_rst,
    input  logic             i_flag,
    input  logic             lock,
    input  logic             ack,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic             pending,
    output logic [7:0]       vec_lo,
    output logic [1:0]       src_kind,
    output logic [ID_W-1:0]  src_id,
    output logic [N_IRQ-1:0] irq_raw
);

    logic [N_IRQ:0]    w_sync;
    logic [N_IRQ-1:0]  w_mask_nxt;
    logic              w_nmi_fall;
    src_kind_t         w_sel_kind;
    logic [7:0]        w_sel_vec;
    logic [ID_W-1:0]   w_sel_id;

    logic              r_rst_act;
    logic              r_nmi_act;
    logic              r_nmi_prev;
    logic [N_IRQ-1:0]  r_irq_act;
    logic [N_IRQ-1:0]  r_irq_raw;
    logic              r_pending;
    logic [7:0]        r_vec_lo;
    src_kind_t         r_src_kind;
    logic [ID_W-1:0]   r_src_id;

    irq_sync #(.W(N_IRQ + 1), .STAGES(SYNC_STAGES)) u_sync (
        .dclk    (dclk),
        .n_reset (n_reset),
        .i_d     ({n_nmi, n_irq}),
        .o_q     (w_sync)
    );

`ifdef IRQ_CTRL_MASK_EN
    logic [N_IRQ-1:0] r_mask;

    always_ff @(posedge dclk or negedge n_reset) begin
        if (!n_reset)     r_mask <= '1;
        else if (mask_we) r_mask <= mask_wdata;
    end

    // A write lands in the same edge's irq_act update, not one cycle later.
    assign w_mask_nxt = mask_we ? mask_wdata : r_mask;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^{mask_we, mask_wdata};
    assign w_mask_nxt    = '1;
`endif

    assign w_nmi_fall = r_nmi_prev & ~w_sync[N_IRQ];

    always_comb begin
        w_sel_kind = SRC_NONE;
        w_sel_vec  = VEC_IRQ0;
        w_sel_id   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (r_irq_act[i]) begin
                w_sel_kind = SRC_IRQ;
                w_sel_vec  = irq_vec(i, VEC_BASE);
                w_sel_id   = ID_W'(i);
            end
        end
        if (r_nmi_act) begin
            w_sel_kind = SRC_NMI;
            w_sel_vec  = VEC_NMI;
            w_sel_id   = '0;
        end
        if (r_rst_act) begin
            w_sel_kind = SRC_RST;
            w_sel_vec  = VEC_RST;
            w_sel_id   = '0;
        end
    end

    always_ff @(posedge dclk or negedge n_reset) begin
        if (!n_reset) begin
            r_rst_act  <= 1'b1;
            r_nmi_act  <= 1'b0;
            r_nmi_prev <= 1'b1;
            r_irq_act  <= '0;
            r_irq_raw  <= '0;
            r_pending  <= 1'b1;
            r_vec_lo   <= VEC_RST;
            r_src_kind <= SRC_RST;
            r_src_id   <= '0;
        end else begin
            // Set terms dominate clears so a coincident new event is never lost.
            r_rst_act  <= soft_rst | (r_rst_act & ~ack);
            r_nmi_act  <= w_nmi_fall | (r_nmi_act & ~(ack & ~r_rst_act));
            r_nmi_prev <= w_sync[N_IRQ];
            r_irq_raw  <= ~w_sync[N_IRQ-1:0];
            r_irq_act  <= ~w_sync[N_IRQ-1:0] & w_mask_nxt;
            r_pending  <= r_rst_act | r_nmi_act | ((|r_irq_act) & ~i_flag);
            if (!lock) begin
                r_vec_lo   <= w_sel_vec;
                r_src_kind <= w_sel_kind;
                r_src_id   <= w_sel_id;
            end
        end
    end

    assign pending  = r_pending;
    assign vec_lo   = r_vec_lo;
    assign src_kind = r_src_kind;
    assign src_id   = r_src_id;
    assign irq_raw  = r_irq_raw;

endmodule
